spi_sample_tx: RTL and testbench

SPI_SAMPLE_TX -- requirements
Module: spi_sample_tx

---
 rtl/spi_pkg.sv | 13 +
 rtl/spi_sample_tx_if.sv | 14 +
 rtl/spi_sample_tx_sync_edge.sv | 40 ++++
 rtl/spi_sample_tx.sv | 154 +++++++++++++++
 tb/tb_spi_sample_tx.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared defaults, underrun fill word and transmit state type
package spi_pkg;

    localparam int          DATA_W_DEF      = 16;
    localparam int          FRAME_WORDS_DEF = 2;
    localparam logic [31:0] UNDERRUN_FILL   = 32'h0000_0000;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } tx_state_e;

endpackage

// File: rtl/spi_sample_tx_if.sv
// rtl/spi_sample_tx_if.sv - sample stream handshake bundle feeding spi_sample_tx
interface spi_sample_tx_if #(
    parameter int DATA_W = spi_pkg::DATA_W_DEF
);

    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic              last;

    modport master (output valid, data, last, input ready);
    modport slave  (input valid, data, last, output ready);

endinterface

// File: rtl/spi_sample_tx_sync_edge.sv
// rtl/spi_sample_tx_sync_edge.sv - 2-FF synchronizer with registered edge detect
module sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Reset value chosen per line so a released reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
            prev_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q;
    assign rise  = sync_q & ~prev_q;
    assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/spi_sample_tx.sv
// rtl/spi_sample_tx.sv - stream-to-SPI-slave transmitter: capture, pending, mode-0 shifter
module spi_sample_tx
    import spi_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int FRAME_WORDS = FRAME_WORDS_DEF
) (
    input  logic           clk,
    input  logic           rst,
    spi_sample_tx_if.slave s,
    input  logic           sck,
    input  logic           cs_n,
    output logic           miso,
    output logic           miso_oe,
    output logic           underrun,
    output logic           sync_err
);

    localparam int SHIFT_W = DATA_W * FRAME_WORDS;
    localparam int CNT_W   = $clog2(FRAME_WORDS + 1);

    logic [SHIFT_W-1:0] capture_q, capture_d;
    logic [SHIFT_W-1:0] pend_q, pend_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   count_inc;
    logic               cap_full_q, cap_full_d;
    logic               pend_valid_q, pend_valid_d;
    logic               underrun_q, underrun_d;
    logic               sync_err_q, sync_err_d;
    tx_state_e          state_q, state_d;

    logic               ready_int;
    logic               accept;
    logic               load_shift;
    logic               sck_level, sck_rise, sck_fall;
    logic               cs_level, cs_rise, cs_fall;
    logic               unused_sync;

    sync_edge #(.RESET_VAL(1'b0)) u_sck_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (sck),
        .level    (sck_level),
        .rise     (sck_rise),
        .fall     (sck_fall)
    );

    sync_edge #(.RESET_VAL(1'b1)) u_cs_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (cs_n),
        .level    (cs_level),
        .rise     (cs_rise),
        .fall     (cs_fall)
    );

    assign unused_sync = ^{sck_level, sck_rise, cs_level};

    assign ready_int = ~rst & ~cap_full_q;
    assign accept    = s.valid & ready_int;
    assign s.ready   = ready_int;
    assign load_shift = (state_q == ST_IDLE) && cs_fall;

    always_comb begin
        capture_d    = capture_q;
        pend_d       = pend_q;
        shift_d      = shift_q;
        count_d      = count_q;
        cap_full_d   = cap_full_q;
        pend_valid_d = pend_valid_q;
        underrun_d   = 1'b0;
        sync_err_d   = 1'b0;
        state_d      = state_q;
        count_inc    = count_q + 1'b1;

        // Beats enter at the bottom, so the first beat ends up in the top word.
        if (accept) begin
            if (s.last && (count_inc == CNT_W'(FRAME_WORDS))) begin
                capture_d  = SHIFT_W'({capture_q, s.data});
                cap_full_d = 1'b1;
                count_d    = '0;
            end else if (s.last || (count_inc == CNT_W'(FRAME_WORDS))) begin
                capture_d  = '0;
                count_d    = '0;
                sync_err_d = 1'b1;
            end else begin
                capture_d  = SHIFT_W'({capture_q, s.data});
                count_d    = count_inc;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d      = ST_ACTIVE;
                    pend_valid_d = 1'b0;
                    if (pend_valid_q) begin
                        shift_d = pend_q;
                    end else begin
                        shift_d    = SHIFT_W'(UNDERRUN_FILL);
                        underrun_d = 1'b1;
                    end
                end
            end
            ST_ACTIVE: begin
                if (cs_rise) begin
                    state_d = ST_IDLE;
                    shift_d = '0;
                end else if (sck_fall) begin
                    shift_d = shift_q << 1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A frame loaded into the shifter this cycle frees pending for the waiting capture.
        if (cap_full_q && (!pend_valid_q || load_shift)) begin
            pend_d       = capture_q;
            pend_valid_d = 1'b1;
            cap_full_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            capture_q    <= '0;
            pend_q       <= '0;
            shift_q      <= '0;
            count_q      <= '0;
            cap_full_q   <= 1'b0;
            pend_valid_q <= 1'b0;
            underrun_q   <= 1'b0;
            sync_err_q   <= 1'b0;
            state_q      <= ST_IDLE;
        end else begin
            capture_q    <= capture_d;
            pend_q       <= pend_d;
            shift_q      <= shift_d;
            count_q      <= count_d;
            cap_full_q   <= cap_full_d;
            pend_valid_q <= pend_valid_d;
            underrun_q   <= underrun_d;
            sync_err_q   <= sync_err_d;
            state_q      <= state_d;
        end
    end

    assign miso_oe  = (state_q == ST_ACTIVE);
    assign miso     = miso_oe & shift_q[SHIFT_W-1];
    assign underrun = underrun_q;
    assign sync_err = sync_err_q;

endmodule

// File: tb/tb_spi_sample_tx.sv
// tb/tb_spi_sample_tx.sv - randomized self-checking bench with a frame-queue reference model
module tb_spi_sample_tx;

    localparam int HALF = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sck = 1'b0;
    logic cs_n = 1'b1;
    logic miso, miso_oe, underrun, sync_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_frames[$];
    logic [15:0] m_beats[$];
    int exp_ur = 0;
    int exp_se = 0;
    int ur_cycles = 0;
    int se_cycles = 0;

    spi_sample_tx_if #(.DATA_W(16)) bus ();

    spi_sample_tx #(.DATA_W(16), .FRAME_WORDS(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .s        (bus),
        .sck      (sck),
        .cs_n     (cs_n),
        .miso     (miso),
        .miso_oe  (miso_oe),
        .underrun (underrun),
        .sync_err (sync_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (underrun === 1'b1) ur_cycles++;
        if (sync_err === 1'b1) se_cycles++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_beat(input logic [15:0] d, input logic l);
        int waited;
        logic [31:0] w;
        waited = 0;
        bus.valid = 1'b1;
        bus.data  = d;
        bus.last  = l;
        while (bus.ready !== 1'b1 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 2000) check("send_timeout", {63'b0, bus.ready}, 64'd1);
        @(negedge clk);
        bus.valid = 1'b0;
        m_beats.push_back(d);
        if (l && m_beats.size() == 2) begin
            w = {m_beats[0], m_beats[1]};
            m_frames.push_back(w);
            m_beats.delete();
        end else if (l || m_beats.size() == 2) begin
            exp_se++;
            m_beats.delete();
        end
    endtask

    task automatic send_frame(input logic [31:0] w);
        send_beat(w[31:16], 1'b0);
        send_beat(w[15:0], 1'b1);
        repeat (3) @(negedge clk);
    endtask

    task automatic spi_read(input int nbits, input string tag, input bit keep_low);
        logic [63:0] got;
        logic [63:0] stream;
        logic [31:0] w;
        got = '0;
        if (m_frames.size() > 0) begin
            w = m_frames.pop_front();
        end else begin
            w = 32'h0;
            exp_ur++;
        end
        stream = {w, 32'h0};
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        check({tag, "_oe"}, {63'b0, miso_oe}, 64'd1);
        for (int i = 0; i < nbits; i++) begin
            repeat (HALF) @(negedge clk);
            got = {got[62:0], miso};
            sck = 1'b1;
            repeat (HALF) @(negedge clk);
            sck = 1'b0;
        end
        check({tag, "_bits"}, got, stream >> (64 - nbits));
        if (!keep_low) begin
            repeat (HALF) @(negedge clk);
            cs_n = 1'b1;
            repeat (6) @(negedge clk);
            check({tag, "_oe_off"}, {63'b0, miso_oe}, 64'd0);
        end
    endtask

    task automatic check_pulses(input string tag);
        check({tag, "_underrun"}, 64'(ur_cycles), 64'(exp_ur));
        check({tag, "_sync_err"}, 64'(se_cycles), 64'(exp_se));
    endtask

    task automatic check_ready(input string tag);
        check({tag, "_ready"}, {63'b0, bus.ready}, {63'b0, (m_frames.size() < 2)});
    endtask

    initial begin
        logic [31:0] w;
        bus.valid = 1'b0;
        bus.data  = '0;
        bus.last  = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_ready", {63'b0, bus.ready}, 64'd0);
        check("rst_oe", {63'b0, miso_oe}, 64'd0);
        check("rst_miso", {63'b0, miso}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", {63'b0, bus.ready}, 64'd1);

        send_beat(16'h1234, 1'b0);
        send_beat(16'hABCD, 1'b1);
        repeat (3) @(negedge clk);
        spi_read(32, "basic", 1'b0);
        check_pulses("basic");

        spi_read(32, "empty", 1'b0);
        check_pulses("empty");

        send_beat(16'h5555, 1'b1);
        repeat (3) @(negedge clk);
        check_pulses("short");
        send_frame(32'h0001_0002);
        spi_read(32, "after_err", 1'b0);
        check_pulses("after_err");

        send_frame(32'h1111_2222);
        send_frame(32'h3333_4444);
        check_ready("full");
        fork
            send_frame(32'h5555_6666);
            spi_read(32, "bp1", 1'b0);
        join
        check_ready("bp_refill");
        spi_read(32, "bp2", 1'b0);
        check_ready("bp_drain");
        spi_read(32, "bp3", 1'b0);
        check_pulses("bp");

        send_frame(32'hDEAD_BEEF);
        send_frame(32'hCAFE_F00D);
        spi_read(10, "abort", 1'b0);
        spi_read(32, "after_abort", 1'b0);
        spi_read(32, "abort_empty", 1'b0);
        check_pulses("abort");

        send_frame(32'h89AB_CDEF);
        send_frame(32'h0F0F_F0F0);
        spi_read(16, "rst_mid", 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_oe", {63'b0, miso_oe}, 64'd0);
        check("mid_rst_ready", {63'b0, bus.ready}, 64'd0);
        sck  = 1'b0;
        cs_n = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        m_frames.delete();
        m_beats.delete();
        #1;
        check("mid_rst_release_ready", {63'b0, bus.ready}, 64'd1);
        @(negedge clk);
        spi_read(32, "post_rst_read", 1'b0);
        check_pulses("post_rst");

        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 5))
                0, 1: if (m_frames.size() < 2) begin
                    w = $urandom;
                    send_frame(w);
                    check_ready("rnd_send");
                end
                2: if (m_frames.size() < 2) begin
                    if ($urandom_range(0, 1) == 0) begin
                        send_beat(16'($urandom), 1'b1);
                    end else begin
                        send_beat(16'($urandom), 1'b0);
                        send_beat(16'($urandom), 1'b0);
                    end
                    repeat (3) @(negedge clk);
                    check_ready("rnd_bad");
                end
                3: spi_read(32, "rnd_full", 1'b0);
                4: spi_read($urandom_range(33, 40), "rnd_long", 1'b0);
                default: spi_read($urandom_range(1, 31), "rnd_abort", 1'b0);
            endcase
            check_pulses("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
